// File: rtl/video_stream_checker_pkg.sv
// Shared FSM state type for the video stream checker.
package SystemPkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    GAP,
    LINE
  } state_t;

endpackage

// File: rtl/video_stream_checker.sv
// Checks an incoming ramp-pattern video stream: measures line/frame geometry,
// compares pixel data against an expected ramp and reports lock status.
module video_stream_checker
  import SystemPkg::*;
#(
  parameter int DSIZE = 24
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             enable,
  input  logic             vsync,
  input  logic             hsync,
  input  logic             de,
  input  logic [DSIZE-1:0] data,
  input  logic [15:0]      exp_hactive,
  input  logic [15:0]      exp_vactive,
  output logic [15:0]      meas_hactive,
  output logic [15:0]      meas_vactive,
  output logic             frame_done,
  output logic             pix_err,
  output logic [15:0]      err_cnt,
  output logic             locked
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           state, state_nxt;
  logic             vsync_r, vsync_d, de_r, de_d, enable_d;
  logic [DSIZE-1:0] data_r, exp_data;
  logic [15:0]      pix_cnt, line_cnt, first_len;
  logic             frame_err;
  logic             close_q, close_err;
  logic [15:0]      close_h, close_v;
  logic [1:0]       good_cnt;

  logic vsync_rise, de_fall, enable_rise;
  logic clear_cnt, start_line, count_pix, end_line, do_close, trunc;
  logic pix_bad, len_bad, err_now, close_good;
  logic [15:0] close_lines, close_hval;
  logic unused_hsync;

  assign unused_hsync = hsync;
  assign vsync_rise   = vsync_r & ~vsync_d;
  assign de_fall      = de_d & ~de_r;
  assign enable_rise  = enable & ~enable_d;

  always_comb begin
    state_nxt  = state;
    clear_cnt  = 1'b0;
    start_line = 1'b0;
    count_pix  = 1'b0;
    end_line   = 1'b0;
    do_close   = 1'b0;
    trunc      = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      clear_cnt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SYNC;
          clear_cnt = 1'b1;
        end
        SYNC: begin
          clear_cnt = 1'b1;
          if (vsync_rise) state_nxt = GAP;
        end
        GAP: begin
          if (vsync_rise) begin
            do_close = 1'b1;
          end else if (de_r) begin
            start_line = 1'b1;
            state_nxt  = LINE;
          end
        end
        LINE: begin
          // A new frame arriving mid-line truncates the current line.
          if (vsync_rise) begin
            do_close  = 1'b1;
            trunc     = 1'b1;
            state_nxt = GAP;
          end else if (de_fall) begin
            end_line  = 1'b1;
            state_nxt = GAP;
          end else if (de_r) begin
            count_pix = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pix_bad     = (start_line && (data_r != '0)) ||
                  (count_pix && (data_r != exp_data));
    len_bad     = end_line && (line_cnt != 16'd0) && (pix_cnt != first_len);
    err_now     = pix_bad | len_bad | trunc;
    close_lines = trunc ? sat_inc(line_cnt) : line_cnt;
    close_hval  = (trunc && (line_cnt == 16'd0)) ? pix_cnt : first_len;
    close_good  = !close_err && (close_h == exp_hactive) && (close_v == exp_vactive);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= IDLE;
      vsync_r  <= 1'b0;
      vsync_d  <= 1'b0;
      de_r     <= 1'b0;
      de_d     <= 1'b0;
      data_r   <= '0;
      enable_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      vsync_r  <= vsync;
      vsync_d  <= vsync_r;
      de_r     <= de;
      de_d     <= de_r;
      data_r   <= data;
      enable_d <= enable;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst || clear_cnt || do_close) begin
      pix_cnt   <= 16'd0;
      line_cnt  <= 16'd0;
      first_len <= 16'd0;
      exp_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (start_line) begin
        pix_cnt  <= 16'd1;
        exp_data <= DSIZE'(1);
      end
      if (count_pix) begin
        pix_cnt  <= sat_inc(pix_cnt);
        exp_data <= exp_data + DSIZE'(1);
      end
      if (end_line) begin
        line_cnt <= sat_inc(line_cnt);
        if (line_cnt == 16'd0) first_len <= pix_cnt;
      end
      if (err_now) frame_err <= 1'b1;
    end
  end

  // Close results are staged one cycle so the outputs land two cycles after vsync is sampled.
  always_ff @(posedge pclk) begin
    if (prst) begin
      close_q   <= 1'b0;
      close_h   <= 16'd0;
      close_v   <= 16'd0;
      close_err <= 1'b0;
    end else begin
      close_q   <= do_close;
      close_h   <= close_hval;
      close_v   <= close_lines;
      close_err <= frame_err | err_now;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      meas_hactive <= 16'd0;
      meas_vactive <= 16'd0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
      good_cnt     <= 2'd0;
    end else begin
      frame_done <= close_q && enable;
      if (!enable) begin
        locked   <= 1'b0;
        good_cnt <= 2'd0;
      end else if (close_q) begin
        meas_hactive <= close_h;
        meas_vactive <= close_v;
        if (close_good) begin
          good_cnt <= (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
          locked   <= (good_cnt != 2'd0);
        end else begin
          good_cnt <= 2'd0;
          locked   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst || enable_rise) begin
      pix_err <= 1'b0;
      err_cnt <= 16'd0;
    end else begin
      if (pix_bad) pix_err <= 1'b1;
      if (err_now) err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Directed bench for video_stream_checker: table of whole frames plus
// hand-written truncation, enable and reset sequences.
module tb_video_stream_checker;

  localparam int DSIZE = 8;
  localparam int HACT  = 300;
  localparam int VACT  = 4;

  typedef struct {
    int lines;
    int hpix;
    int bad_line;
    int bad_pix;
    int short_line;
    int exp_h;
    int exp_v;
    int exp_err;
    int exp_pix;
    int exp_lock;
  } vec_t;

  logic             pclk = 1'b0;
  logic             prst, enable, vsync, hsync, de;
  logic [DSIZE-1:0] data;
  logic [15:0]      exp_hactive, exp_vactive;
  logic [15:0]      meas_hactive, meas_vactive, err_cnt;
  logic             frame_done, pix_err, locked;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[10];

  always #5 pclk = ~pclk;

  video_stream_checker #(.DSIZE(DSIZE)) dut (
    .pclk        (pclk),
    .prst        (prst),
    .enable      (enable),
    .vsync       (vsync),
    .hsync       (hsync),
    .de          (de),
    .data        (data),
    .exp_hactive (exp_hactive),
    .exp_vactive (exp_vactive),
    .meas_hactive(meas_hactive),
    .meas_vactive(meas_vactive),
    .frame_done  (frame_done),
    .pix_err     (pix_err),
    .err_cnt     (err_cnt),
    .locked      (locked)
  );

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one active line of ramp data (optionally corrupting one pixel) then a short blanking gap.
  task automatic apply_stimulus(input int npix, input int bad_pix);
    logic [DSIZE-1:0] d;
    for (int p = 0; p < npix; p++) begin
      d = DSIZE'(p);
      if (p == bad_pix) d = d ^ 8'h55;
      de   = 1'b1;
      data = d;
      hsync = 1'b0;
      step();
    end
    de    = 1'b0;
    data  = '0;
    hsync = 1'b1;
    repeat (4) step();
    hsync = 1'b0;
  endtask

  task automatic send_frame(input int lines, input int hpix, input int bad_line,
                            input int bad_pix, input int short_line);
    for (int l = 0; l < lines; l++)
      apply_stimulus((l == short_line) ? hpix - 1 : hpix, (l == bad_line) ? bad_pix : -1);
  endtask

  task automatic vsync_pulse(input logic exp_done, input string tag);
    vsync = 1'b1;
    de    = 1'b0;
    step();
    step();
    check_output($sformatf("%s done early", tag), frame_done, 0);
    vsync = 1'b0;
    step();
    check_output($sformatf("%s done", tag), frame_done, exp_done);
    step();
    check_output($sformatf("%s done width", tag), frame_done, 0);
    repeat (2) step();
  endtask

  task automatic check_frame(input string tag, input int h, input int v, input int err,
                             input int pix, input int lock);
    check_output($sformatf("%s meas_hactive", tag), meas_hactive, h);
    check_output($sformatf("%s meas_vactive", tag), meas_vactive, v);
    check_output($sformatf("%s err_cnt", tag), err_cnt, err);
    check_output($sformatf("%s pix_err", tag), pix_err, pix);
    check_output($sformatf("%s locked", tag), locked, lock);
  endtask

  task automatic check_all_zero(input string tag);
    check_frame(tag, 0, 0, 0, 0, 0);
    check_output($sformatf("%s frame_done", tag), frame_done, 0);
  endtask

  initial begin
    prst        = 1'b1;
    enable      = 1'b0;
    vsync       = 1'b0;
    hsync       = 1'b0;
    de          = 1'b0;
    data        = '0;
    exp_hactive = 16'(HACT);
    exp_vactive = 16'(VACT);

    // lines, hpix, bad_line, bad_pix, short_line, meas_h, meas_v, err_cnt, pix_err, locked
    vecs[0] = '{4, 300, -1,  -1, -1, 300, 4, 0, 0, 0};
    vecs[1] = '{4, 300, -1,  -1, -1, 300, 4, 0, 0, 1};
    vecs[2] = '{4, 300, -1,  -1, -1, 300, 4, 0, 0, 1};
    vecs[3] = '{4, 300,  2, 100, -1, 300, 4, 1, 1, 0};
    vecs[4] = '{4, 300, -1,  -1, -1, 300, 4, 1, 1, 0};
    vecs[5] = '{4, 300, -1,  -1,  2, 300, 4, 2, 1, 0};
    vecs[6] = '{4, 300, -1,  -1, -1, 300, 4, 2, 1, 0};
    vecs[7] = '{4, 300, -1,  -1, -1, 300, 4, 2, 1, 1};
    vecs[8] = '{0, 300, -1,  -1, -1,   0, 0, 2, 1, 0};
    vecs[9] = '{3,  10, -1,  -1, -1,  10, 3, 2, 1, 0};

    repeat (2) step();
    check_all_zero("reset");
    prst   = 1'b0;
    enable = 1'b1;
    repeat (3) step();
    vsync_pulse(1'b0, "first vsync");

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].lines, vecs[i].hpix, vecs[i].bad_line, vecs[i].bad_pix, vecs[i].short_line);
      vsync_pulse(1'b1, $sformatf("vec%0d", i));
      check_frame($sformatf("vec%0d", i), vecs[i].exp_h, vecs[i].exp_v,
                  vecs[i].exp_err, vecs[i].exp_pix, vecs[i].exp_lock);
    end

    $display("[TB] truncated line sequence");
    apply_stimulus(HACT, -1);
    for (int p = 0; p < 50; p++) begin
      de   = 1'b1;
      data = DSIZE'(p);
      step();
    end
    data  = DSIZE'(50);
    vsync = 1'b1;
    step();
    de    = 1'b0;
    data  = '0;
    step();
    check_output("trunc done early", frame_done, 0);
    vsync = 1'b0;
    step();
    check_output("trunc done", frame_done, 1);
    step();
    check_output("trunc done width", frame_done, 0);
    repeat (2) step();
    check_frame("trunc", 300, 2, 3, 1, 0);
    send_frame(VACT, HACT, -1, -1, -1);
    vsync_pulse(1'b1, "after trunc 1");
    check_frame("after trunc 1", 300, 4, 3, 1, 0);
    send_frame(VACT, HACT, -1, -1, -1);
    vsync_pulse(1'b1, "after trunc 2");
    check_frame("after trunc 2", 300, 4, 3, 1, 1);

    $display("[TB] enable sequence");
    enable = 1'b0;
    step();
    check_frame("disabled", 300, 4, 3, 1, 0);
    repeat (3) step();
    enable = 1'b1;
    step();
    check_output("re-enable err_cnt", err_cnt, 0);
    check_output("re-enable pix_err", pix_err, 0);
    repeat (2) step();
    vsync_pulse(1'b0, "resync");
    send_frame(VACT, HACT, 0, 7, -1);
    vsync_pulse(1'b1, "after enable");
    check_frame("after enable", 300, 4, 1, 1, 0);

    $display("[TB] reset mid-line sequence");
    for (int p = 0; p < 20; p++) begin
      de   = 1'b1;
      data = DSIZE'(p);
      step();
    end
    prst = 1'b1;
    step();
    check_all_zero("mid-line reset");
    prst = 1'b0;
    de   = 1'b0;
    data = '0;
    repeat (4) step();
    vsync_pulse(1'b0, "post-reset vsync");
    send_frame(VACT, HACT, -1, -1, -1);
    vsync_pulse(1'b1, "post-reset close");
    check_frame("post-reset close", 300, 4, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
